// File: rtl/generic_fifo_pkg.sv
// Shared constants and helpers for the single-clock generic FIFO.
// The defaults here seed the FIFO parameters; ptr_width sizes the pointers and the level.
package generic_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_DEPTH      = 16;

  // One extra MSB beyond the address bits tells full apart from empty.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/generic_fifo_ram.sv
// Simple dual-port RAM with a synchronous write port and a registered read port.
// Only the read register is reset; the array contents keep their values through reset.
module generic_fifo_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // rd_data holds its value whenever no read is issued.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/generic_fifo_dc.sv
// Single-clock FIFO: the pointers, level and status flags live here; storage is generic_fifo_ram.
// Flags are decoded from the registered pointers, so they follow each accepted operation by one cycle.
module generic_fifo_dc
  import generic_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int DEPTH           = DEF_DEPTH,
  parameter int ALMOST_FULL_TH  = DEPTH - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int PW             = ptr_width(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [PW-1:0]         level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = PW - 1;
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wr_acc;
  logic          rd_acc;

  assign empty        = (wptr == rptr);
  assign full         = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level        = wptr - rptr;
  assign almost_full  = (level >= AF_TH);
  assign almost_empty = (level <= AE_TH);

  // A write on a full FIFO or a read on an empty one is dropped without side effects.
  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr       <= '0;
      rptr       <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
      read_valid <= rd_acc;
      overflow   <= write_en && full;
      underflow  <= read_en && empty;
    end
  end

  generic_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (AW)
  ) u_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_acc),
    .wr_addr (wptr[AW-1:0]),
    .wr_data (write_data),
    .rd_en   (rd_acc),
    .rd_addr (rptr[AW-1:0]),
    .rd_data (read_data)
  );

endmodule

// File: tb/tb_generic_fifo_dc.sv
// Randomized self-checking bench for generic_fifo_dc against a queue-based FIFO model.
module tb_generic_fifo_dc;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF_TH = DEPTH - 2;
  localparam int AE_TH = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          write_en = 1'b0;
  logic          read_en = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          read_valid, full, empty, almost_full, almost_empty;
  logic [4:0]    level;
  logic          overflow, underflow;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_rd = '0;
  bit            exp_rv = 0;
  bit            exp_ovf = 0;
  bit            exp_udf = 0;

  generic_fifo_dc #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .write_en     (write_en),
    .write_data   (write_data),
    .read_en      (read_en),
    .read_data    (read_data),
    .read_valid   (read_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("level",        32'(level),        32'(sz));
    chk("empty",        32'(empty),        32'(sz == 0));
    chk("full",         32'(full),         32'(sz == DEPTH));
    chk("almost_full",  32'(almost_full),  32'(sz >= AF_TH));
    chk("almost_empty", 32'(almost_empty), 32'(sz <= AE_TH));
    chk("read_valid",   32'(read_valid),   32'(exp_rv));
    chk("overflow",     32'(overflow),     32'(exp_ovf));
    chk("underflow",    32'(underflow),    32'(exp_udf));
    chk("read_data",    32'(read_data),    32'(exp_rd));
  endtask

  // Drive one cycle of requests, advance the model across the edge, check just after it.
  task automatic step(input bit we, input bit re, input logic [DW-1:0] d);
    bit was_full, was_empty;
    write_en   = we;
    read_en    = re;
    write_data = d;
    @(posedge clock);
    was_full  = (q.size() == DEPTH);
    was_empty = (q.size() == 0);
    exp_rv  = 0;
    exp_ovf = we && was_full;
    exp_udf = re && was_empty;
    if (re && !was_empty) begin
      exp_rd = q.pop_front();
      exp_rv = 1;
    end
    if (we && !was_full) q.push_back(d);
    #1;
    check_all();
  endtask

  task automatic model_reset();
    q.delete();
    exp_rd  = '0;
    exp_rv  = 0;
    exp_ovf = 0;
    exp_udf = 0;
  endtask

  initial begin
    int wp, rp;
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;

    repeat (100) step(0, 0, '0);

    for (int i = 0; i < 17; i++) step(1, 0, DW'(i + 1));
    step(0, 0, '0);
    for (int i = 0; i < 17; i++) step(0, 1, '0);
    step(0, 0, '0);

    for (int i = 0; i < 5; i++) step(1, 0, DW'($urandom));
    for (int i = 0; i < 100; i++) step(1, 1, DW'($urandom));
    while (q.size() > 0) step(0, 1, '0);

    step(1, 1, 8'hAA);
    step(0, 1, '0);
    step(0, 0, '0);

    for (int i = 0; i < 3000; i++) begin
      if ((i / 200) % 2 == 0) begin wp = 75; rp = 35; end
      else                    begin wp = 35; rp = 75; end
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom));
    end

    while (q.size() > 0) step(0, 1, '0);
    for (int i = 0; i < 9; i++) step(1, 0, DW'(8'h30 + i));
    write_en = 1'b0;
    read_en  = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;
    step(1, 0, 8'h5C);
    step(0, 1, '0);
    step(0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/generic_fifo_dc.md
GENERIC_FIFO_DC -- requirements
Module: generic_fifo_dc

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each stored word.
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, at least 4.
REQ-003 Parameter ALMOST_FULL_TH, default DEPTH-2; almost_full asserts when level >= this value.
REQ-004 Parameter ALMOST_EMPTY_TH, default 2; almost_empty asserts when level <= this value.
REQ-005 Port clock, input, 1 bit; single clock; every register samples on the rising edge.
REQ-006 Port reset, input, 1 bit; asynchronous, active-low reset.
REQ-007 Port write_en, input, 1 bit; write request.
REQ-008 Port write_data, input, DATA_WIDTH bits; word to be written.
REQ-009 Port read_en, input, 1 bit; read request.
REQ-010 Port read_data, output, DATA_WIDTH bits; registered read word.
REQ-011 Port read_valid, output, 1 bit; read_data is valid this cycle.
REQ-012 Port full, output, 1 bit; level == DEPTH.
REQ-013 Port empty, output, 1 bit; level == 0.
REQ-014 Port almost_full, output, 1 bit; threshold flag.
REQ-015 Port almost_empty, output, 1 bit; threshold flag.
REQ-016 Port level, output, log2(DEPTH)+1 bits; current occupancy.
REQ-017 Port overflow, output, 1 bit; one-cycle pulse when a write is rejected.
REQ-018 Port underflow, output, 1 bit; one-cycle pulse when a read is rejected.

Function
REQ-019 A write is accepted when write_en=1 and full=0; the word is stored at the write pointer and the write pointer increments by 1.
REQ-020 A read is accepted when read_en=1 and empty=0; the word at the read pointer is loaded into read_data on the same edge, read_valid=1 in the following cycle, and the read pointer increments by 1.
REQ-021 Read latency is exactly 1 cycle; read_valid=0 in any cycle that does not follow an accepted read; read_data holds its last value when no read is accepted.
REQ-022 Pointers are log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; the low bits address memory; full means the MSBs differ and the low bits are equal; empty means the pointers are equal.
REQ-023 level = write pointer minus read pointer, modulo 2*DEPTH; it updates on the edge after each accepted operation.
REQ-024 All status flags (full, empty, almost_full, almost_empty) are derived combinationally from the registered pointers, so they reflect accepted operations one cycle later.
REQ-025 Simultaneous read and write when 0 < level < DEPTH: both operations are accepted and level is unchanged.
REQ-026 Simultaneous read and write when empty: only the write is accepted, underflow pulses, and the new word becomes readable in the next cycle; there is no fall-through.
REQ-027 Simultaneous read and write when full: only the read is accepted, overflow pulses, and the rejected write data is discarded.
REQ-028 Rejected operations never change the pointers, the memory, or read_data.
REQ-029 Data is returned in strict FIFO order across pointer wrap-around.

Reset
REQ-030 While reset=0: both pointers = 0, level = 0, empty = 1, almost_empty = 1, full = 0, almost_full = 0, read_valid = 0, read_data = 0, overflow = 0, underflow = 0.
REQ-031 Reset asserted mid-operation clears all state immediately, with no dependence on the clock; memory contents are not cleared and are never observable after reset.
REQ-032 After reset releases, the first accepted write is possible on the first rising edge.

Structure
REQ-033 A shared package generic_fifo_pkg holds the default width and depth constants and a function that computes the pointer width.
REQ-034 Storage is one sub-module, generic_fifo_ram, a simple dual-port RAM with one synchronous write port and one synchronous registered read port on clock; the pointer and flag logic lives in the top level.

Verification
REQ-035 Release reset, idle for 100 cycles -> empty=1, level=0, read_valid=0, overflow=0, underflow=0 throughout.
REQ-036 Write 0x01..0x10 with DEPTH=16 -> full=1, level=16, almost_full asserted from level 14; a 17th write gives overflow=1 for one cycle and level stays 16.
REQ-037 Read 16 words back -> read_data is 0x01..0x10 in order, each one cycle after read_en; empty=1 at the end; a further read gives underflow=1 for one cycle.
REQ-038 Hold write_en and read_en continuously for 100 cycles with level=5 -> level stays 5, data stays in order, and the pointers wrap at least 6 times.
REQ-039 Simultaneous write and read on an empty FIFO with data 0xAA -> underflow=1 and level=1; the next read returns 0xAA.
REQ-040 Pull reset low asynchronously between clock edges at level=9 -> all outputs take their reset values immediately; after release, a write then a read returns the new word.
